// File: rtl/dcpu16_abus_fsm.sv
// dcpu16_abus_fsm
//
// Operand-fetch unit. It resolves both operand encodings (a then b) of an
// instruction over one read-only, ack-driven memory port. This covers
// next-word fetches, [next word + register] address adds and PUSH/POP
// stack-pointer updates. The unit owns the SP register.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              request resolution of ea_a/ea_b (accepted when !busy)
//   ea_a, ea_b         6-bit operand encodings
//   rrd_a, rrd_b       register-file values selected by ea_x[2:0]
//   regPC              address of the first next word
//   regO               overflow register
//   sp_we, sp_wd       external SP write (honoured only in IDLE without start)
//   ab_adr/ab_stb      registered memory address and read strobe
//   ab_wre             always 0 (read-only port)
//   ab_dti/ab_ack      read data and acknowledge
//   busy, done         transaction in progress / one-cycle completion pulse
//   regA, regB         resolved operand values
//   tgt_adr            effective address of b when b is a memory operand, else 0
//   pc_nxt             regPC plus the number of next words consumed
//   regSP              current stack pointer
//
// state | meaning
// IDLE  | waiting for start; sp_we accepted here
// NW_A  | fetching next word for operand a
// LD_A  | loading operand a from memory
// NW_B  | fetching next word for operand b
// LD_B  | loading operand b from memory
// DONE  | done pulse, outputs valid
module dcpu16_abus_fsm #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter logic [AW-1:0] SP_INIT = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [5:0]    ea_a,
    input  logic [5:0]    ea_b,
    input  logic [DW-1:0] rrd_a,
    input  logic [DW-1:0] rrd_b,
    input  logic [AW-1:0] regPC,
    input  logic [DW-1:0] regO,
    input  logic          sp_we,
    input  logic [AW-1:0] sp_wd,
    output logic [AW-1:0] ab_adr,
    output logic          ab_stb,
    output logic          ab_wre,
    input  logic [DW-1:0] ab_dti,
    input  logic          ab_ack,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] regA,
    output logic [DW-1:0] regB,
    output logic [AW-1:0] tgt_adr,
    output logic [AW-1:0] pc_nxt,
    output logic [AW-1:0] regSP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NW_A,
        S_LD_A,
        S_NW_B,
        S_LD_B,
        S_DONE
    } state_t;

    state_t        state;
    logic [5:0]    ea_a_q, ea_b_q;
    logic [DW-1:0] rrd_a_q, rrd_b_q, o_q;
    logic [AW-1:0] pc_q;

    assign ab_wre = 1'b0;

    function automatic logic needs_nw(input logic [5:0] ea);
        return (ea >= 6'h10 && ea <= 6'h17) || ea == 6'h1e || ea == 6'h1f;
    endfunction

    function automatic logic needs_ld(input logic [5:0] ea);
        return (ea >= 6'h08 && ea <= 6'h1a) || ea == 6'h1e;
    endfunction

    // Load address for operands that need no next word.
    function automatic logic [AW-1:0] plain_adr(input logic [5:0] ea,
                                                input logic [DW-1:0] rrd,
                                                input logic [AW-1:0] sp);
        if (ea == 6'h18 || ea == 6'h19)
            return sp;
        else if (ea == 6'h1a)
            return sp - AW'(1);
        else
            return AW'(rrd);
    endfunction

    // Load address once the next word is known.
    function automatic logic [AW-1:0] nw_adr(input logic [5:0] ea,
                                             input logic [DW-1:0] nw,
                                             input logic [DW-1:0] rrd);
        if (ea == 6'h1e)
            return AW'(nw);
        else
            return AW'(nw) + AW'(rrd);
    endfunction

    function automatic logic [AW-1:0] sp_after(input logic [5:0] ea,
                                               input logic [AW-1:0] sp);
        if (ea == 6'h18)
            return sp + AW'(1);
        else if (ea == 6'h1a)
            return sp - AW'(1);
        else
            return sp;
    endfunction

    // Value of operands resolved without memory. Memory operands overwrite
    // this later, so the fall-through value is irrelevant for them.
    function automatic logic [DW-1:0] direct_val(input logic [5:0] ea,
                                                 input logic [DW-1:0] rrd,
                                                 input logic [AW-1:0] sp,
                                                 input logic [AW-1:0] pc,
                                                 input logic [DW-1:0] o);
        if (ea[5])
            return DW'(ea[4:0]);
        else if (ea == 6'h1b)
            return DW'(sp);
        else if (ea == 6'h1c)
            return DW'(pc);
        else if (ea == 6'h1d)
            return o;
        else
            return rrd;
    endfunction

    // Operand b entry context. b may be entered from IDLE (inputs not yet
    // registered) or from the acking cycle of a's last access, where SP and
    // the next-word pointer are being updated on the same edge.
    logic [5:0]    eb;
    logic [DW-1:0] rb, ob, b_val;
    logic [AW-1:0] pcb, sp_a_commit, sp_b, ptr_b, b_adr, a_adr;
    state_t        b_first;
    logic          a_fin;

    always_comb begin
        eb          = (state == S_IDLE) ? ea_b  : ea_b_q;
        rb          = (state == S_IDLE) ? rrd_b : rrd_b_q;
        ob          = (state == S_IDLE) ? regO  : o_q;
        pcb         = (state == S_IDLE) ? regPC : pc_q;
        sp_a_commit = sp_after(ea_a_q, regSP);
        sp_b        = (state == S_LD_A) ? sp_a_commit : regSP;
        if (state == S_IDLE)
            ptr_b = regPC;
        else if (state == S_NW_A)
            ptr_b = pc_nxt + AW'(1);
        else
            ptr_b = pc_nxt;
        if (needs_nw(eb))
            b_first = S_NW_B;
        else if (needs_ld(eb))
            b_first = S_LD_B;
        else
            b_first = S_DONE;
        b_adr = needs_nw(eb) ? ptr_b : plain_adr(eb, rb, sp_b);
        b_val = direct_val(eb, rb, sp_b, pcb, ob);
        a_adr = needs_nw(ea_a_q) ? pc_nxt : plain_adr(ea_a_q, rrd_a_q, regSP);
        a_fin = ab_stb && ab_ack &&
                ((state == S_LD_A) || (state == S_NW_A && ea_a_q == 6'h1f));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ea_a_q  <= '0;
            ea_b_q  <= '0;
            rrd_a_q <= '0;
            rrd_b_q <= '0;
            o_q     <= '0;
            pc_q    <= '0;
            ab_adr  <= '0;
            ab_stb  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            regA    <= '0;
            regB    <= '0;
            tgt_adr <= '0;
            pc_nxt  <= '0;
            regSP   <= SP_INIT;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        ea_a_q  <= ea_a;
                        ea_b_q  <= ea_b;
                        rrd_a_q <= rrd_a;
                        rrd_b_q <= rrd_b;
                        o_q     <= regO;
                        pc_q    <= regPC;
                        pc_nxt  <= regPC;
                        busy    <= 1'b1;
                        tgt_adr <= '0;
                        regA    <= direct_val(ea_a, rrd_a, regSP, regPC, regO);
                        if (needs_nw(ea_a)) begin
                            state <= S_NW_A;
                        end else if (needs_ld(ea_a)) begin
                            state <= S_LD_A;
                        end else begin
                            regB  <= b_val;
                            state <= b_first;
                            if (b_first == S_DONE)
                                done <= 1'b1;
                        end
                    end else if (sp_we) begin
                        regSP <= sp_wd;
                    end
                end
                S_NW_A: begin
                    if (!ab_stb) begin
                        ab_stb <= 1'b1;
                        ab_adr <= a_adr;
                    end else if (ab_ack) begin
                        pc_nxt <= pc_nxt + AW'(1);
                        if (ea_a_q == 6'h1f) begin
                            regA <= ab_dti;
                        end else begin
                            state  <= S_LD_A;
                            ab_adr <= nw_adr(ea_a_q, ab_dti, rrd_a_q);
                        end
                    end
                end
                S_LD_A: begin
                    if (!ab_stb) begin
                        ab_stb <= 1'b1;
                        ab_adr <= a_adr;
                    end else if (ab_ack) begin
                        regA  <= ab_dti;
                        regSP <= sp_a_commit;
                    end
                end
                S_NW_B: begin
                    if (!ab_stb) begin
                        ab_stb <= 1'b1;
                        ab_adr <= b_adr;
                    end else if (ab_ack) begin
                        pc_nxt <= pc_nxt + AW'(1);
                        if (ea_b_q == 6'h1f) begin
                            regB   <= ab_dti;
                            state  <= S_DONE;
                            done   <= 1'b1;
                            ab_stb <= 1'b0;
                        end else begin
                            state   <= S_LD_B;
                            ab_adr  <= nw_adr(ea_b_q, ab_dti, rrd_b_q);
                            tgt_adr <= nw_adr(ea_b_q, ab_dti, rrd_b_q);
                        end
                    end
                end
                S_LD_B: begin
                    if (!ab_stb) begin
                        ab_stb  <= 1'b1;
                        ab_adr  <= b_adr;
                        tgt_adr <= b_adr;
                    end else if (ab_ack) begin
                        regB   <= ab_dti;
                        regSP  <= sp_after(ea_b_q, regSP);
                        state  <= S_DONE;
                        done   <= 1'b1;
                        ab_stb <= 1'b0;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // a finished on this edge: move straight into b, issuing its
            // first access without an idle strobe cycle.
            if (a_fin) begin
                regB  <= b_val;
                state <= b_first;
                if (b_first == S_DONE) begin
                    done   <= 1'b1;
                    ab_stb <= 1'b0;
                end else begin
                    ab_stb <= 1'b1;
                    ab_adr <= b_adr;
                    if (b_first == S_LD_B)
                        tgt_adr <= b_adr;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcpu16_abus_fsm.sv
module tb_dcpu16_abus_fsm;

    localparam logic [15:0] SP0 = 16'h8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  ea_a, ea_b;
    logic [15:0] rrd_a, rrd_b, regPC, regO;
    logic        sp_we;
    logic [15:0] sp_wd;
    logic [15:0] ab_adr;
    logic        ab_stb, ab_wre;
    logic [15:0] ab_dti;
    logic        ab_ack;
    logic        busy, done;
    logic [15:0] regA, regB, tgt_adr, pc_nxt, regSP;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] acc_q[$];
    int          waits = 0;
    int          wcnt  = 0;

    dcpu16_abus_fsm #(.AW(16), .DW(16), .SP_INIT(SP0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ea_a(ea_a), .ea_b(ea_b), .rrd_a(rrd_a), .rrd_b(rrd_b),
        .regPC(regPC), .regO(regO), .sp_we(sp_we), .sp_wd(sp_wd),
        .ab_adr(ab_adr), .ab_stb(ab_stb), .ab_wre(ab_wre),
        .ab_dti(ab_dti), .ab_ack(ab_ack),
        .busy(busy), .done(done), .regA(regA), .regB(regB),
        .tgt_adr(tgt_adr), .pc_nxt(pc_nxt), .regSP(regSP)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after 'waits' strobe cycles, logs acked addresses.
    always @(negedge clk) begin
        if (rst || !ab_stb) begin
            ab_ack = 1'b0;
            wcnt   = 0;
        end else if (wcnt < waits) begin
            ab_ack = 1'b0;
            wcnt   = wcnt + 1;
        end else begin
            ab_ack = 1'b1;
            ab_dti = mem[ab_adr];
            acc_q.push_back(ab_adr);
            wcnt   = 0;
        end
    end

    task automatic launch(input logic [5:0] a, input logic [5:0] b,
                          input logic [15:0] ra, input logic [15:0] rb,
                          input logic [15:0] pc);
        @(negedge clk);
        acc_q.delete();
        ea_a = a; ea_b = b; rrd_a = ra; rrd_b = rb; regPC = pc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok, output bit saw_stb);
        cyc = 0; ok = 1'b0; saw_stb = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (ab_stb) saw_stb = 1'b1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_sp(input logic [15:0] v);
        @(negedge clk);
        sp_we = 1'b1; sp_wd = v;
        @(posedge clk);
        #1 sp_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({ab_stb, busy, done, ab_wre} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b required 0000", {ab_stb, busy, done, ab_wre});
        end
        n_checks++;
        if ({regA, regB} !== 32'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h required 0", {regA, regB});
        end
        n_checks++;
        if ({ab_adr, tgt_adr, pc_nxt} !== 48'h0) begin
            n_fail++; $display("FAIL reset_adr: got %h required 0", {ab_adr, tgt_adr, pc_nxt});
        end
        n_checks++;
        if (regSP !== SP0) begin
            n_fail++; $display("FAIL reset_sp: got %h required %h", regSP, SP0);
        end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        int cyc; bit ok, stb;
        launch(6'h00, 6'h25, 16'h1234, 16'h9999, 16'h0300);
        wait_done(cyc, ok, stb);
        n_checks++;
        if (!ok || cyc != 1) begin
            n_fail++; $display("FAIL direct_latency: got %0d (ok=%0d) required 1", cyc, ok);
        end
        n_checks++;
        if ({regA, regB} !== {16'h1234, 16'h0005}) begin
            n_fail++; $display("FAIL direct_vals: got %h required 12340005", {regA, regB});
        end
        n_checks++;
        if ({pc_nxt, tgt_adr} !== {16'h0300, 16'h0000}) begin
            n_fail++; $display("FAIL direct_pc_tgt: got %h required 03000000", {pc_nxt, tgt_adr});
        end
        n_checks++;
        if (stb !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL direct_stb_busy: got stb=%0d busy=%0d required 0/1", stb, busy);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL direct_after: got %b required 00", {busy, done});
        end
    endtask

    task automatic test_special_regs();
        int cyc; bit ok, stb;
        set_sp(16'h4321);
        @(negedge clk);
        n_checks++;
        if (regSP !== 16'h4321) begin
            n_fail++; $display("FAIL sp_we: got %h required 4321", regSP);
        end
        regO = 16'h0F0F;
        launch(6'h1c, 6'h1d, 16'h0, 16'h0, 16'h0777);
        wait_done(cyc, ok, stb);
        n_checks++;
        if (!ok || {regA, regB} !== {16'h0777, 16'h0F0F}) begin
            n_fail++; $display("FAIL pc_o_vals: got %h required 07770f0f", {regA, regB});
        end
        launch(6'h1b, 6'h3f, 16'h0, 16'h0, 16'h0010);
        wait_done(cyc, ok, stb);
        n_checks++;
        if (!ok || {regA, regB} !== {16'h4321, 16'h001F}) begin
            n_fail++; $display("FAIL sp_lit_vals: got %h required 4321001f", {regA, regB});
        end
    endtask

    task automatic test_nw_ind();
        int cyc; bit ok, stb;
        waits = 0;
        mem[16'h0100] = 16'h0200;
        mem[16'h0200] = 16'hBEEF;
        launch(6'h1e, 6'h20, 16'h0, 16'h0, 16'h0100);
        wait_done(cyc, ok, stb);
        n_checks++;
        if (!ok || cyc != 4) begin
            n_fail++; $display("FAIL nw_ind_latency: got %0d required 4", cyc);
        end
        n_checks++;
        if (acc_q.size() != 2 || acc_q[0] !== 16'h0100 || acc_q[1] !== 16'h0200) begin
            n_fail++; $display("FAIL nw_ind_adrs: got %p required 0100,0200", acc_q);
        end
        n_checks++;
        if ({regA, regB, pc_nxt, tgt_adr} !== {16'hBEEF, 16'h0000, 16'h0101, 16'h0000}) begin
            n_fail++; $display("FAIL nw_ind_vals: got %h required beef000001010000", {regA, regB, pc_nxt, tgt_adr});
        end
    endtask

    task automatic test_nw_plus_reg();
        int cyc; bit ok, stb;
        mem[16'h0040] = 16'h0005;
        mem[16'h0041] = 16'h7777;
        mem[16'h0015] = 16'hAAAA;
        launch(6'h11, 6'h1f, 16'h0010, 16'h0, 16'h0040);
        wait_done(cyc, ok, stb);
        n_checks++;
        if (!ok || cyc != 5) begin
            n_fail++; $display("FAIL nwreg_latency: got %0d required 5", cyc);
        end
        n_checks++;
        if (acc_q.size() != 3 || acc_q[0] !== 16'h0040 || acc_q[1] !== 16'h0015 || acc_q[2] !== 16'h0041) begin
            n_fail++; $display("FAIL nwreg_adrs: got %p required 0040,0015,0041", acc_q);
        end
        n_checks++;
        if ({regA, regB, pc_nxt} !== {16'hAAAA, 16'h7777, 16'h0042}) begin
            n_fail++; $display("FAIL nwreg_vals: got %h required aaaa77770042", {regA, regB, pc_nxt});
        end
    endtask

    task automatic test_push_pop();
        int cyc; bit ok, stb;
        set_sp(16'h0000);
        mem[16'hFFFF] = 16'h0101;
        launch(6'h1a, 6'h18, 16'h0, 16'h0, 16'h0500);
        wait_done(cyc, ok, stb);
        n_checks++;
        if (!ok || cyc != 4) begin
            n_fail++; $display("FAIL pushpop_latency: got %0d required 4", cyc);
        end
        n_checks++;
        if (acc_q.size() != 2 || acc_q[0] !== 16'hFFFF || acc_q[1] !== 16'hFFFF) begin
            n_fail++; $display("FAIL pushpop_adrs: got %p required ffff,ffff", acc_q);
        end
        n_checks++;
        if ({regA, regB} !== {16'h0101, 16'h0101}) begin
            n_fail++; $display("FAIL pushpop_vals: got %h required 01010101", {regA, regB});
        end
        n_checks++;
        if ({regSP, tgt_adr} !== {16'h0000, 16'hFFFF}) begin
            n_fail++; $display("FAIL pushpop_sp_tgt: got %h required 0000ffff", {regSP, tgt_adr});
        end
    endtask

    task automatic test_start_beats_sp_we();
        int cyc; bit ok, stb;
        @(negedge clk);
        ea_a = 6'h1b; ea_b = 6'h20; regPC = 16'h0;
        start = 1'b1; sp_we = 1'b1; sp_wd = 16'h5555;
        @(posedge clk);
        #1 start = 1'b0; sp_we = 1'b0;
        wait_done(cyc, ok, stb);
        @(negedge clk);
        n_checks++;
        if ({regA, regSP} !== {16'h0000, 16'h0000}) begin
            n_fail++; $display("FAIL start_vs_spwe: got %h required 00000000", {regA, regSP});
        end
    endtask

    task automatic test_wait_states();
        int  cyc = 0;
        int  stb_cyc = 0;
        bit  ok = 1'b0;
        bit  moved = 1'b0;
        waits = 3;
        mem[16'h0050] = 16'h1357;
        launch(6'h08, 6'h21, 16'h0050, 16'h0, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                ea_a = 6'h20; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (ab_stb) begin
                stb_cyc++;
                if (ab_adr !== 16'h0050) moved = 1'b1;
            end
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!ok || cyc != 6) begin
            n_fail++; $display("FAIL wait_latency: got %0d required 6", cyc);
        end
        n_checks++;
        if (stb_cyc != 4 || moved) begin
            n_fail++; $display("FAIL wait_stb_hold: got %0d cycles moved=%0d required 4/0", stb_cyc, moved);
        end
        n_checks++;
        if ({regA, regB} !== {16'h1357, 16'h0001}) begin
            n_fail++; $display("FAIL wait_vals: got %h required 13570001", {regA, regB});
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, regA} !== {2'b00, 16'h1357}) begin
            n_fail++; $display("FAIL busy_start_ignored: got %h required 01357", {busy, done, regA});
        end
        waits = 0;
    endtask

    task automatic test_pc_wrap();
        int cyc; bit ok, stb;
        mem[16'hFFFF] = 16'h1111;
        mem[16'h0000] = 16'h2222;
        launch(6'h1f, 6'h1f, 16'h0, 16'h0, 16'hFFFF);
        wait_done(cyc, ok, stb);
        n_checks++;
        if (!ok || {regA, regB, pc_nxt} !== {16'h1111, 16'h2222, 16'h0001}) begin
            n_fail++; $display("FAIL pc_wrap: got %h required 111122220001", {regA, regB, pc_nxt});
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok, stb;
        set_sp(16'h1234);
        mem[16'h1234] = 16'hCAFE;
        mem[SP0]      = 16'h5A5A;
        waits = 10;
        launch(6'h20, 6'h18, 16'h0, 16'h0, 16'h0600);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ab_stb, ab_adr, busy} !== {1'b1, 16'h1234, 1'b1}) begin
            n_fail++; $display("FAIL mid_pre_reset: got %h required 1 1234 1", {ab_stb, ab_adr, busy});
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ab_stb, busy, done} !== 3'b000 || {regA, regB} !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_ctl: got %b %h required 000 0", {ab_stb, busy, done}, {regA, regB});
        end
        n_checks++;
        if ({ab_adr, tgt_adr, pc_nxt, regSP} !== {48'h0, SP0}) begin
            n_fail++; $display("FAIL mid_reset_adr_sp: got %h required 0 %h", {ab_adr, tgt_adr, pc_nxt, regSP}, SP0);
        end
        rst = 1'b0;
        waits = 0;
        launch(6'h19, 6'h20, 16'h0, 16'h0, 16'h0700);
        wait_done(cyc, ok, stb);
        n_checks++;
        if (!ok || cyc != 3 || {regA, regSP} !== {16'h5A5A, SP0}) begin
            n_fail++; $display("FAIL after_reset_peek: got %0d %h required 3 5a5a%h", cyc, {regA, regSP}, SP0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sp_we = 1'b0; sp_wd = '0;
        ea_a = '0; ea_b = '0; rrd_a = '0; rrd_b = '0; regPC = '0; regO = '0;
        ab_ack = 1'b0; ab_dti = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_direct();
        test_special_regs();
        test_nw_ind();
        test_nw_plus_reg();
        test_push_pop();
        test_start_beats_sp_we();
        test_wait_states();
        test_pc_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
